dm_access_unit: RTL and testbench

//  Data-memory stage downstream of the instruction decoder: consumes DMWE/SLCtrl plus ALU address and
//  rt data, performs byte/half/word/unaligned-word stores with byte enables into a word-wide RAM, and

---
 rtl/dm_access_unit_if.sv | 25 ++
 rtl/dm_access_unit.sv | 182 ++++++++++++++++++
 tb/tb_dm_access_unit.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dm_access_unit_if.sv
// rtl/dm_access_unit_if.sv - request/response bundle between decoder stage and data memory unit
interface dm_access_unit_if;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_slctrl;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] req_rt_old;
  logic        ready;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        addr_err;

  // Requester side: issues loads/stores, receives load data and error pulses.
  modport master (
    output req_valid, req_we, req_slctrl, req_addr, req_wdata, req_rt_old,
    input  ready, rdata, rdata_valid, addr_err
  );

  // Memory side.
  modport slave (
    input  req_valid, req_we, req_slctrl, req_addr, req_wdata, req_rt_old,
    output ready, rdata, rdata_valid, addr_err
  );
endinterface

// File: rtl/dm_access_unit.sv
// rtl/dm_access_unit.sv - data memory stage with byte-enable stores, extending/merging loads, init clear
module dm_access_unit #(
  parameter int ADDR_WIDTH = 10,
  parameter bit INIT_CLEAR = 1'b1
) (
  input logic             clk,
  input logic             rst_n,
  dm_access_unit_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  localparam logic [2:0] SL_WORD  = 3'd1;
  localparam logic [2:0] SL_HALF  = 3'd2;
  localparam logic [2:0] SL_BYTE  = 3'd3;
  localparam logic [2:0] SL_LEFT  = 3'd4;
  localparam logic [2:0] SL_RIGHT = 3'd5;
  localparam logic [2:0] SL_HALFU = 3'd6;
  localparam logic [2:0] SL_BYTEU = 3'd7;

  typedef enum logic {
    ST_INIT,
    ST_IDLE
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] clr_idx;
  logic                  ready_q;
  logic [31:0]           rdata_q;
  logic                  rdata_valid_q;
  logic                  addr_err_q;

  logic [31:0]           mem [DEPTH];

  logic [1:0]            b;
  logic [ADDR_WIDTH-1:0] widx;
  logic                  accept;
  logic                  misaligned;
  logic                  do_store;
  logic                  do_load;
  logic [4:0]            sh_lo;
  logic [4:0]            sh_hi;
  logic [3:0]            st_be;
  logic [31:0]           st_data;
  logic [31:0]           mword;
  logic [31:0]           lane;
  logic [31:0]           load_res;
  logic                  unused_addr_hi;

  // Address bits above the RAM index are deliberately ignored so the address wraps.
  assign unused_addr_hi = ^bus.req_addr[31:ADDR_WIDTH+2];

  assign b     = bus.req_addr[1:0];
  assign widx  = bus.req_addr[ADDR_WIDTH+1:2];
  // sh_lo = 8*b, sh_hi = 8*(3-b); for a 2-bit b, 3-b is simply ~b.
  assign sh_lo = {b, 3'b000};
  assign sh_hi = {~b, 3'b000};

  assign accept   = ready_q & bus.req_valid & (bus.req_slctrl != 3'd0);
  assign do_store = accept & ~misaligned & bus.req_we;
  assign do_load  = accept & ~misaligned & ~bus.req_we;

  // Asynchronous read lets a load issued the cycle after a store see the stored data.
  assign mword = mem[widx];
  assign lane  = mword >> sh_lo;

  // Word needs a word boundary, halves need an even address; everything else is always legal.
  always_comb begin
    misaligned = 1'b0;
    case (bus.req_slctrl)
      SL_WORD:           misaligned = (b != 2'd0);
      SL_HALF, SL_HALFU: misaligned = b[0];
      default:           misaligned = 1'b0;
    endcase
  end

  // Byte enables and lane-positioned store data, little-endian.
  always_comb begin
    st_be   = 4'b0000;
    st_data = 32'd0;
    case (bus.req_slctrl)
      SL_WORD: begin
        st_be   = 4'b1111;
        st_data = bus.req_wdata;
      end
      SL_HALF: begin
        st_be   = 4'b0011 << b;
        st_data = {16'd0, bus.req_wdata[15:0]} << sh_lo;
      end
      SL_BYTE: begin
        st_be   = 4'b0001 << b;
        st_data = {24'd0, bus.req_wdata[7:0]} << sh_lo;
      end
      SL_LEFT: begin
        st_be   = 4'b1111 >> (~b);
        st_data = bus.req_wdata >> sh_hi;
      end
      SL_RIGHT: begin
        st_be   = 4'b1111 << b;
        st_data = bus.req_wdata << sh_lo;
      end
      default: begin
        st_be   = 4'b0000;
        st_data = 32'd0;
      end
    endcase
  end

  // Load result formatting: extension for sub-word loads, rt merge for left/right loads.
  always_comb begin
    load_res = 32'd0;
    case (bus.req_slctrl)
      SL_WORD:  load_res = mword;
      SL_HALF:  load_res = {{16{lane[15]}}, lane[15:0]};
      SL_HALFU: load_res = {16'd0, lane[15:0]};
      SL_BYTE:  load_res = {{24{lane[7]}}, lane[7:0]};
      SL_BYTEU: load_res = {24'd0, lane[7:0]};
      SL_LEFT:  load_res = (mword << sh_hi) |
                           (bus.req_rt_old & ~(32'hFFFF_FFFF << sh_hi));
      SL_RIGHT: load_res = (mword >> sh_lo) |
                           (bus.req_rt_old & ~(32'hFFFF_FFFF >> sh_lo));
      default:  load_res = 32'd0;
    endcase
  end

  // RAM write port: zero fill while initialising, otherwise byte-enabled stores.
  always_ff @(posedge clk) begin
    if (state == ST_INIT) begin
      mem[clr_idx] <= 32'd0;
    end else if (do_store) begin
      for (int i = 0; i < 4; i++) begin
        if (st_be[i]) begin
          mem[widx][8*i +: 8] <= st_data[8*i +: 8];
        end
      end
    end
  end

  // Control FSM: sweep the clear index once after reset, then stay in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= INIT_CLEAR ? ST_INIT : ST_IDLE;
      ready_q <= !INIT_CLEAR;
      clr_idx <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          clr_idx <= clr_idx + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
          if (clr_idx == '1) begin
            state   <= ST_IDLE;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state   <= ST_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Response register: single-cycle pulses; rdata only changes on a performed load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q       <= 32'd0;
      rdata_valid_q <= 1'b0;
      addr_err_q    <= 1'b0;
    end else begin
      rdata_valid_q <= do_load;
      addr_err_q    <= accept & misaligned;
      if (do_load) begin
        rdata_q <= load_res;
      end
    end
  end

  assign bus.ready       = ready_q;
  assign bus.rdata       = rdata_q;
  assign bus.rdata_valid = rdata_valid_q;
  assign bus.addr_err    = addr_err_q;

endmodule

// File: tb/tb_dm_access_unit.sv
// tb/tb_dm_access_unit.sv - scoreboard bench for dm_access_unit with byte-level reference model
module tb_dm_access_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  dm_access_unit_if bus ();

  dm_access_unit #(
    .ADDR_WIDTH(4),
    .INIT_CLEAR(1'b1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic        err;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  mb [64];
  logic [31:0] last_rdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 64; i++) mb[i] = 8'h00;
    last_rdata = 32'd0;
    exp_q.delete();
  endtask

  // Monitor: every response pulse must match the oldest expectation, in kind, cycle and data.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (bus.rdata_valid === 1'b1 || bus.addr_err === 1'b1)) begin : mon
      exp_t e;
      chk("pulse_exclusive", 32'(bus.rdata_valid & bus.addr_err), 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", {30'd0, bus.addr_err, bus.rdata_valid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("resp_kind", {30'd0, bus.addr_err, bus.rdata_valid}, e.err ? 32'd2 : 32'd1);
        chk("resp_cycle", 32'(cyc), 32'(e.cyc));
        chk("resp_data", bus.rdata, e.data);
      end
    end
  end

  task automatic rand_drive();
    bus.req_valid  = 1'($urandom);
    bus.req_we     = 1'($urandom);
    bus.req_slctrl = 3'($urandom);
    bus.req_addr   = $urandom;
    bus.req_wdata  = $urandom;
    bus.req_rt_old = $urandom;
  endtask

  // Counts INIT cycles with random traffic applied; optionally resets once mid-way.
  task automatic init_wait(input int abort_at);
    int cnt = 0;
    bit aborted = 1'b0;
    while (cnt < 16) begin
      if (cnt == abort_at && !aborted) begin
        aborted = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("midinit_ready", 32'(bus.ready), 32'd0);
        chk("midinit_rdata", bus.rdata, 32'd0);
        chk("midinit_valid", 32'(bus.rdata_valid), 32'd0);
        chk("midinit_err", 32'(bus.addr_err), 32'd0);
        clear_model();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cnt = 0;
      end else begin
        chk("init_ready_low", 32'(bus.ready), 32'd0);
        rand_drive();
        @(posedge clk);
        #1;
        cnt++;
      end
    end
    bus.req_valid = 1'b0;
    chk("init_ready_high", 32'(bus.ready), 32'd1);
  endtask

  task automatic do_reset(input int abort_at);
    #2;
    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    #1;
    chk("rst_ready", 32'(bus.ready), 32'd0);
    chk("rst_rdata", bus.rdata, 32'd0);
    chk("rst_valid", 32'(bus.rdata_valid), 32'd0);
    chk("rst_err", 32'(bus.addr_err), 32'd0);
    clear_model();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    init_wait(abort_at);
  endtask

  // Issue one request for the next edge; the model applies its effect and queues the response.
  task automatic issue(input logic we, input logic [2:0] sl, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] rt,
                       input bit use_want, input logic [31:0] want);
    int          b;
    int          base;
    bit          mis;
    logic [7:0]  m [4];
    logic [15:0] h;
    logic [31:0] res;
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_slctrl = sl;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    bus.req_rt_old = rt;
    if (sl != 3'd0) begin
      b    = int'(addr[1:0]);
      base = int'(addr[5:2]) * 4;
      mis  = (sl == 3'd1 && b != 0) || ((sl == 3'd2 || sl == 3'd6) && (b % 2 == 1));
      if (mis) begin
        exp_q.push_back('{1'b1, last_rdata, cyc + 1});
      end else if (we) begin
        case (sl)
          3'd1: for (int i = 0; i < 4; i++) mb[base+i] = wd[8*i +: 8];
          3'd2: begin
            mb[base+b]   = wd[7:0];
            mb[base+b+1] = wd[15:8];
          end
          3'd3: mb[base+b] = wd[7:0];
          3'd4: for (int i = 0; i <= b; i++) mb[base+i] = wd[8*(i+3-b) +: 8];
          3'd5: for (int i = b; i < 4; i++) mb[base+i] = wd[8*(i-b) +: 8];
          default: ;
        endcase
      end else begin
        for (int i = 0; i < 4; i++) m[i] = mb[base+i];
        res = 32'd0;
        case (sl)
          3'd1: res = {m[3], m[2], m[1], m[0]};
          3'd2: begin
            h = {m[b+1], m[b]};
            res = {{16{h[15]}}, h};
          end
          3'd6: begin
            h = {m[b+1], m[b]};
            res = {16'd0, h};
          end
          3'd3: res = {{24{m[b][7]}}, m[b]};
          3'd7: res = {24'd0, m[b]};
          3'd4: begin
            for (int i = 0; i < 4; i++) begin
              if (i >= 3 - b) res[8*i +: 8] = m[i-(3-b)];
              else            res[8*i +: 8] = rt[8*i +: 8];
            end
          end
          default: begin
            for (int i = 0; i < 4; i++) begin
              if (i <= 3 - b) res[8*i +: 8] = m[i+b];
              else            res[8*i +: 8] = rt[8*i +: 8];
            end
          end
        endcase
        if (use_want) res = want;
        last_rdata = res;
        exp_q.push_back('{1'b0, res, cyc + 1});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.req_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_slctrl = 3'd0;
    bus.req_addr   = 32'd0;
    bus.req_wdata  = 32'd0;
    bus.req_rt_old = 32'd0;
    clear_model();

    do_reset(-1);

    // Cleared RAM reads back zero.
    issue(1'b0, 3'd1, 32'h0000_000C, 32'd0, 32'd0, 1'b1, 32'h0000_0000);

    // Word store, byte overwrite, extended byte loads, word readback.
    issue(1'b1, 3'd1, 32'h0000_0008, 32'h1122_3344, 32'd0, 1'b0, 32'd0);
    issue(1'b1, 3'd3, 32'h0000_000A, 32'h0000_00AA, 32'd0, 1'b0, 32'd0);
    issue(1'b0, 3'd3, 32'h0000_000A, 32'd0, 32'd0, 1'b1, 32'hFFFF_FFAA);
    issue(1'b0, 3'd7, 32'h0000_000A, 32'd0, 32'd0, 1'b1, 32'h0000_00AA);
    issue(1'b0, 3'd1, 32'h0000_0008, 32'd0, 32'd0, 1'b1, 32'h11AA_3344);
    idle(2);

    // Left/right merging loads.
    issue(1'b1, 3'd1, 32'h0000_0000, 32'h1122_3344, 32'd0, 1'b0, 32'd0);
    issue(1'b0, 3'd4, 32'h0000_0001, 32'd0, 32'hDEAD_BEEF, 1'b1, 32'h3344_BEEF);
    issue(1'b0, 3'd5, 32'h0000_0002, 32'd0, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_1122);
    idle(1);

    // Left/right partial stores.
    issue(1'b1, 3'd1, 32'h0000_0004, 32'h0000_0000, 32'd0, 1'b0, 32'd0);
    issue(1'b1, 3'd4, 32'h0000_0005, 32'hAABB_CCDD, 32'd0, 1'b0, 32'd0);
    issue(1'b0, 3'd1, 32'h0000_0004, 32'd0, 32'd0, 1'b1, 32'h0000_AABB);
    issue(1'b1, 3'd5, 32'h0000_0006, 32'h1122_3344, 32'd0, 1'b0, 32'd0);
    issue(1'b0, 3'd1, 32'h0000_0004, 32'd0, 32'd0, 1'b1, 32'h3344_AABB);
    idle(1);

    // Misaligned word load and half store, then readback of the untouched word.
    issue(1'b0, 3'd1, 32'h0000_0002, 32'd0, 32'd0, 1'b0, 32'd0);
    issue(1'b1, 3'd2, 32'h0000_0003, 32'h0000_FFFF, 32'd0, 1'b0, 32'd0);
    idle(1);
    issue(1'b0, 3'd1, 32'h0000_0000, 32'd0, 32'd0, 1'b1, 32'h1122_3344);
    idle(2);

    // Reset mid-INIT, then reset while a load response is pending.
    do_reset(5);
    issue(1'b1, 3'd1, 32'h0000_0010, 32'hCAFE_F00D, 32'd0, 1'b0, 32'd0);
    idle(1);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b0;
    bus.req_slctrl = 3'd1;
    bus.req_addr   = 32'h0000_0010;
    @(posedge clk);
    #1;
    chk("pending_valid", 32'(bus.rdata_valid), 32'd1);
    chk("pending_data", bus.rdata, 32'hCAFE_F00D);
    do_reset(-1);
    issue(1'b0, 3'd1, 32'h0000_0010, 32'd0, 32'd0, 1'b1, 32'h0000_0000);

    // Randomised mix with idle gaps, no-ops and wrapping addresses.
    for (int n = 0; n < 600; n++) begin
      logic        we;
      logic [2:0]  sl;
      logic [31:0] addr;
      if ($urandom_range(0, 3) == 0) begin
        rand_drive();
        bus.req_valid = 1'b0;
        @(posedge clk);
        #1;
      end else begin
        we   = 1'($urandom);
        sl   = we ? 3'($urandom_range(0, 5)) : 3'($urandom_range(0, 7));
        addr = $urandom;
        if ($urandom_range(0, 1) == 0) addr = addr & 32'h0000_001F;
        issue(we, sl, addr, $urandom, $urandom, 1'b0, 32'd0);
      end
    end

    idle(4);
    chk("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
